// File: rtl/tl_mem_slave.sv
// tl_mem_slave: TileLink-UL/UH slave memory, 128-bit beats, one outstanding
// transaction. Serves Get (burst read) and PutFullData/PutPartialData (burst
// write with byte mask) from an internal RAM of 2^DEPTH_LOG2 x 128-bit words.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   tlslv_a_*          TileLink A channel (request): opcode, param (ignored),
//                      size, source, address, mask, data, corrupt, valid/ready
//   tlslv_d_*          TileLink D channel (response): opcode, param, size,
//                      source, sink, denied, data, corrupt, valid/ready
//
// RAM starts all zero. Reset never touches RAM.
module tl_mem_slave #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   tlslv_a_opcode,
  input  logic [2:0]   tlslv_a_param,
  input  logic [7:0]   tlslv_a_size,
  input  logic [2:0]   tlslv_a_source,
  input  logic [31:0]  tlslv_a_address,
  input  logic [15:0]  tlslv_a_mask,
  input  logic [127:0] tlslv_a_data,
  input  logic         tlslv_a_corrupt,
  input  logic         tlslv_a_valid,
  output logic         tlslv_a_ready,
  output logic [2:0]   tlslv_d_opcode,
  output logic [1:0]   tlslv_d_param,
  output logic [7:0]   tlslv_d_size,
  output logic [2:0]   tlslv_d_source,
  output logic [2:0]   tlslv_d_sink,
  output logic         tlslv_d_denied,
  output logic [127:0] tlslv_d_data,
  output logic         tlslv_d_corrupt,
  output logic         tlslv_d_valid,
  input  logic         tlslv_d_ready
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned IDX_W  = DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BEAT_W-1:0]   r_beat, w_beat_nxt, r_last, w_a_last;
  logic [IDX_W-1:0]    r_base, w_a_word, w_wr_idx, w_rd_idx;
  logic [2:0]          r_source;
  logic [7:0]          r_size;
  logic                r_denied, r_data_resp, r_a_ready, r_d_valid;
  logic [DATA_W-1:0]   r_d_data, w_rd_word;
  logic                w_a_fire, w_d_fire, w_size_ok, w_is_get, w_is_put;
  logic                w_resp_done, w_wr_en, w_rd_en, w_latch;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // RAM start-up contents; reset deliberately leaves the array alone
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // param and out-of-range address bits carry no meaning here
  logic w_unused;
  assign w_unused = ^{tlslv_a_param, tlslv_a_address[31:4+IDX_W], tlslv_a_address[3:0]};

  assign w_a_fire    = tlslv_a_valid & r_a_ready;
  assign w_d_fire    = r_d_valid & tlslv_d_ready;
  assign w_a_word    = tlslv_a_address[4 +: IDX_W];
  assign w_rd_word   = r_mem[w_rd_idx];
  // Put and denied responses are a single beat; Get ends on its last beat
  assign w_resp_done = r_denied | ~r_data_resp | (r_beat == r_last);

  // Request decode: supported opcode/size and burst length minus one
  always_comb begin
    w_size_ok = (tlslv_a_size <= 8'd8);
    w_is_get  = w_size_ok && (tlslv_a_opcode == 3'd4);
    w_is_put  = w_size_ok && ((tlslv_a_opcode == 3'd0) || (tlslv_a_opcode == 3'd1));
    case (tlslv_a_size)
      8'd5:    w_a_last = 4'd1;
      8'd6:    w_a_last = 4'd3;
      8'd7:    w_a_last = 4'd7;
      8'd8:    w_a_last = 4'd15;
      default: w_a_last = 4'd0;
    endcase
  end

  // Next state, beat counter and RAM port controls
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_base + IDX_W'(r_beat);
    w_rd_en     = 1'b0;
    w_rd_idx    = w_a_word;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_a_fire) begin
          w_latch    = 1'b1;
          w_beat_nxt = 4'd0;
          if (w_is_get) begin
            w_rd_en     = 1'b1;
            w_state_nxt = ST_RESP;
          end else if (w_is_put) begin
            w_wr_en  = ~tlslv_a_corrupt;
            w_wr_idx = w_a_word;
            if (w_a_last == 4'd0) begin
              w_state_nxt = ST_RESP;
            end else begin
              w_state_nxt = ST_WRITE;
              w_beat_nxt  = 4'd1;
            end
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_WRITE: begin
        if (w_a_fire) begin
          w_wr_en = ~tlslv_a_corrupt;
          if (r_beat == r_last) w_state_nxt = ST_RESP;
          else                  w_beat_nxt  = r_beat + 4'd1;
        end
      end
      ST_RESP: begin
        if (w_d_fire) begin
          if (w_resp_done) begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = 4'd0;
          end else begin
            // prefetch the next read beat into the output register
            w_beat_nxt = r_beat + 4'd1;
            w_rd_en    = 1'b1;
            w_rd_idx   = r_base + IDX_W'(r_beat + 4'd1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request fields and registered D-channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_last      <= '0;
      r_base      <= '0;
      r_source    <= '0;
      r_size      <= '0;
      r_denied    <= 1'b0;
      r_data_resp <= 1'b0;
      r_a_ready   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_a_ready <= (w_state_nxt != ST_RESP);
      r_d_valid <= (w_state_nxt == ST_RESP);
      if (w_latch) begin
        r_source    <= tlslv_a_source;
        r_size      <= tlslv_a_size;
        r_base      <= w_a_word;
        r_last      <= w_a_last;
        r_denied    <= ~(w_is_get | w_is_put);
        // bit 2 marks Get-like opcodes, which answer with AccessAckData
        r_data_resp <= tlslv_a_opcode[2];
      end
      if (w_rd_en)      r_d_data <= w_rd_word;
      else if (w_latch) r_d_data <= '0;
    end
  end

  // Byte-lane masked RAM write
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (tlslv_a_mask[i]) r_mem[w_wr_idx][8*i +: 8] <= tlslv_a_data[8*i +: 8];
      end
    end
  end

  assign tlslv_a_ready   = r_a_ready;
  assign tlslv_d_opcode  = {2'b00, r_data_resp};
  assign tlslv_d_param   = 2'b00;
  assign tlslv_d_size    = r_size;
  assign tlslv_d_source  = r_source;
  assign tlslv_d_sink    = 3'b000;
  assign tlslv_d_denied  = r_denied;
  assign tlslv_d_data    = r_d_data;
  assign tlslv_d_corrupt = 1'b0;
  assign tlslv_d_valid   = r_d_valid;

endmodule

// File: tb/tb_tl_mem_slave.sv
// tb_tl_mem_slave: randomized scoreboard bench for tl_mem_slave.
module tb_tl_mem_slave;

  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   tlslv_a_opcode = '0;
  logic [2:0]   tlslv_a_param = '0;
  logic [7:0]   tlslv_a_size = '0;
  logic [2:0]   tlslv_a_source = '0;
  logic [31:0]  tlslv_a_address = '0;
  logic [15:0]  tlslv_a_mask = '0;
  logic [127:0] tlslv_a_data = '0;
  logic         tlslv_a_corrupt = 1'b0;
  logic         tlslv_a_valid = 1'b0;
  logic         tlslv_a_ready;
  logic [2:0]   tlslv_d_opcode;
  logic [1:0]   tlslv_d_param;
  logic [7:0]   tlslv_d_size;
  logic [2:0]   tlslv_d_source;
  logic [2:0]   tlslv_d_sink;
  logic         tlslv_d_denied;
  logic [127:0] tlslv_d_data;
  logic         tlslv_d_corrupt;
  logic         tlslv_d_valid;
  logic         tlslv_d_ready = 1'b1;

  typedef struct packed {
    logic [2:0]   opcode;
    logic [7:0]   size;
    logic [2:0]   source;
    logic         denied;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] mdl [DEPTH];
  int           checks = 0;
  int           errors = 0;
  bit           rdy_random = 1'b0;
  bit           prev_stall = 1'b0;
  bit           prev_more = 1'b0;
  logic [127:0] held_data;

  tl_mem_slave #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst),
    .tlslv_a_opcode(tlslv_a_opcode), .tlslv_a_param(tlslv_a_param),
    .tlslv_a_size(tlslv_a_size), .tlslv_a_source(tlslv_a_source),
    .tlslv_a_address(tlslv_a_address), .tlslv_a_mask(tlslv_a_mask),
    .tlslv_a_data(tlslv_a_data), .tlslv_a_corrupt(tlslv_a_corrupt),
    .tlslv_a_valid(tlslv_a_valid), .tlslv_a_ready(tlslv_a_ready),
    .tlslv_d_opcode(tlslv_d_opcode), .tlslv_d_param(tlslv_d_param),
    .tlslv_d_size(tlslv_d_size), .tlslv_d_source(tlslv_d_source),
    .tlslv_d_sink(tlslv_d_sink), .tlslv_d_denied(tlslv_d_denied),
    .tlslv_d_data(tlslv_d_data), .tlslv_d_corrupt(tlslv_d_corrupt),
    .tlslv_d_valid(tlslv_d_valid), .tlslv_d_ready(tlslv_d_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // RAM word touched by beat b of a burst at byte address addr
  function automatic int widx(input logic [31:0] addr, input int b);
    int unsigned w;
    w = (addr >> 4) + b;
    return int'(w % DEPTH);
  endfunction

  function automatic int nbeats(input logic [7:0] size);
    return (size > 8'd4) ? (1 << (size - 8'd4)) : 1;
  endfunction

  // Monitor: drives d_ready for the coming edge, then pops/compares on a D fire
  always @(negedge clk) begin
    exp_t e;
    tlslv_d_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst) begin
      prev_stall = 1'b0;
      prev_more  = 1'b0;
    end else begin
      if (prev_more && !rdy_random) chk("beat_back_to_back", 128'(tlslv_d_valid), 128'(1));
      if (prev_stall) begin
        chk("stall_valid_held", 128'(tlslv_d_valid), 128'(1));
        chk("stall_data_held", tlslv_d_data, held_data);
      end
      prev_stall = 1'b0;
      prev_more  = 1'b0;
      if (tlslv_d_valid) begin
        if (tlslv_d_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: got opcode %0d data %0h, expected none",
                     tlslv_d_opcode, tlslv_d_data);
          end else begin
            e = exp_q.pop_front();
            chk("d_fields", 128'({tlslv_d_opcode, tlslv_d_size, tlslv_d_source, tlslv_d_denied,
                                  tlslv_d_param, tlslv_d_sink, tlslv_d_corrupt}),
                128'({e.opcode, e.size, e.source, e.denied, 2'b00, 3'b000, 1'b0}));
            chk("d_data", tlslv_d_data, e.data);
            prev_more = !e.last;
          end
        end else begin
          prev_stall = 1'b1;
          held_data  = tlslv_d_data;
        end
      end
    end
  end

  // Present one A beat from a negedge and hold it until accepted
  task automatic drive_beat(input logic [2:0] op, input logic [7:0] size, input logic [2:0] src,
                            input logic [31:0] addr, input logic [15:0] mask,
                            input logic [127:0] data, input logic corrupt, input int gap);
    int n;
    tlslv_a_valid = 1'b0;
    repeat (gap) @(negedge clk);
    tlslv_a_opcode  = op;
    tlslv_a_param   = 3'($urandom);
    tlslv_a_size    = size;
    tlslv_a_source  = src;
    tlslv_a_address = addr;
    tlslv_a_mask    = mask;
    tlslv_a_data    = data;
    tlslv_a_corrupt = corrupt;
    tlslv_a_valid   = 1'b1;
    n = 0;
    while (!tlslv_a_ready && n <= 200) begin
      @(negedge clk);
      n++;
    end
    if (n > 200) begin
      checks++;
      errors++;
      $display("FAIL a_ready_timeout: got a_ready 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    tlslv_a_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL response_timeout: got %0d responses pending, expected 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  // One full transaction: expectations from the model, then A beats
  task automatic do_txn(input logic [2:0] op, input logic [7:0] size, input logic [31:0] addr,
                        input bit rnd, input logic [15:0] mask_in, input logic [127:0] dbase,
                        input int gap_in, input int corrupt_beat);
    logic [2:0]   src;
    logic [15:0]  m;
    logic [127:0] d;
    logic         c;
    int           n;
    bit           ok_size;
    src     = 3'($urandom);
    n       = nbeats(size);
    ok_size = (size <= 8'd8);
    if (ok_size && op == 3'd4) begin
      for (int b = 0; b < n; b++)
        exp_q.push_back('{3'd1, size, src, 1'b0, mdl[widx(addr, b)], b == n - 1});
      drive_beat(op, size, src, addr, 16'($urandom), '0, 1'b0, 0);
    end else if (ok_size && (op == 3'd0 || op == 3'd1)) begin
      exp_q.push_back('{3'd0, size, src, 1'b0, 128'd0, 1'b1});
      for (int b = 0; b < n; b++) begin
        m = rnd ? 16'($urandom) : mask_in;
        d = rnd ? {$urandom, $urandom, $urandom, $urandom} : dbase + 128'(b);
        c = rnd ? ($urandom_range(0, 7) == 0) : (b == corrupt_beat);
        if (!c)
          for (int i = 0; i < 16; i++)
            if (m[i]) mdl[widx(addr, b)][8*i +: 8] = d[8*i +: 8];
        if (b == 0)
          drive_beat(op, size, src, addr, m, d, c, 0);
        else if (rnd)
          drive_beat(3'($urandom), 8'($urandom), 3'($urandom), $urandom, m, d, c,
                     $urandom_range(0, 2));
        else
          drive_beat(op, size, src, addr, m, d, c, gap_in);
      end
    end else begin
      exp_q.push_back('{op[2] ? 3'd1 : 3'd0, size, src, 1'b1, 128'd0, 1'b1});
      drive_beat(op, size, src, addr, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
    end
    wait_done();
  endtask

  initial begin
    logic [127:0] rd0, rd1;
    logic [2:0]   op;
    logic [7:0]   size;
    logic [31:0]  addr;
    int           r;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;

    // reset behaviour
    @(negedge clk);
    chk("reset_a_ready", 128'(tlslv_a_ready), 128'(0));
    chk("reset_d_valid", 128'(tlslv_d_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_a_ready", 128'(tlslv_a_ready), 128'(1));
    chk("idle_d_valid", 128'(tlslv_d_valid), 128'(0));

    // PutFull burst with a valid gap, then read it back at full rate
    do_txn(3'd0, 8'd5, 32'h0, 1'b0, 16'hFFFF, 128'd1, 2, -1);
    do_txn(3'd4, 8'd5, 32'h0, 1'b0, '0, '0, 0, -1);
    // read of untouched words with d_ready stalls
    rdy_random = 1'b1;
    do_txn(3'd4, 8'd5, 32'h20, 1'b0, '0, '0, 0, -1);
    rdy_random = 1'b0;
    // partial write into a fully written word
    do_txn(3'd0, 8'd4, 32'h10, 1'b0, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 0, -1);
    do_txn(3'd1, 8'd4, 32'h10, 1'b0, 16'h000F, 128'hAABBCCDD, 0, -1);
    do_txn(3'd4, 8'd4, 32'h10, 1'b0, '0, '0, 0, -1);
    // unsupported requests leave RAM untouched
    do_txn(3'd2, 8'd4, 32'h10, 1'b0, '0, '0, 0, -1);
    do_txn(3'd0, 8'd9, 32'h10, 1'b0, '0, '0, 0, -1);
    do_txn(3'd4, 8'd9, 32'h10, 1'b0, '0, '0, 0, -1);
    do_txn(3'd4, 8'd4, 32'h10, 1'b0, '0, '0, 0, -1);
    // corrupt beat is dropped
    do_txn(3'd0, 8'd5, 32'h60, 1'b0, 16'hFFFF, 128'h1234_0000, 0, 1);
    do_txn(3'd4, 8'd5, 32'h60, 1'b0, '0, '0, 0, -1);
    // address wrap beyond RAM depth, including a burst crossing the top
    do_txn(3'd0, 8'd4, 32'h4000_0030, 1'b0, 16'hFFFF, 128'hCAFE, 0, -1);
    do_txn(3'd4, 8'd4, 32'h30, 1'b0, '0, '0, 0, -1);
    do_txn(3'd0, 8'd6, 32'h3FE0, 1'b0, 16'hFFFF, 128'h5000, 0, -1);
    do_txn(3'd4, 8'd6, 32'h3FE0, 1'b0, '0, '0, 0, -1);
    do_txn(3'd4, 8'd5, 32'h0, 1'b0, '0, '0, 0, -1);

    // reset in the middle of a burst keeps the beats already written
    rd0 = {$urandom, $urandom, $urandom, $urandom};
    rd1 = {$urandom, $urandom, $urandom, $urandom};
    drive_beat(3'd0, 8'd6, 3'd5, 32'h100, 16'hFFFF, rd0, 1'b0, 0);
    drive_beat(3'd0, 8'd6, 3'd5, 32'h100, 16'hFFFF, rd1, 1'b0, 0);
    mdl[16] = rd0;
    mdl[17] = rd1;
    rst = 1'b1;
    #1;
    chk("midreset_a_ready", 128'(tlslv_a_ready), 128'(0));
    chk("midreset_d_valid", 128'(tlslv_d_valid), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_a_ready", 128'(tlslv_a_ready), 128'(1));
    do_txn(3'd4, 8'd6, 32'h100, 1'b0, '0, '0, 0, -1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = 3'd0;
      else if (r < 5) op = 3'd1;
      else if (r < 9) op = 3'd4;
      else            op = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
      size = ($urandom_range(0, 9) == 0) ? 8'd9 : 8'($urandom_range(0, 6));
      addr = {18'($urandom),
              ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(1016, 1023)),
              4'($urandom)};
      rdy_random = 1'($urandom_range(0, 1));
      do_txn(op, size, addr, 1'b1, '0, '0, 0, -1);
    end
    rdy_random = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("final_d_valid", 128'(tlslv_d_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
